// File: rtl/counter_pkg.sv
// Shared definitions for the counter sweep sequencer: mode encodings,
// FSM states and default datapath widths.
package counter_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/updown_core.sv
// Up/down counter register: parallel load has priority over stepping.
module updown_core
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  // Counter register; rst is active-low and asynchronous
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= up ? q + 1'b1 : q - 1'b1;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer: accepts a range/mode/pass-count command and walks the
// updown_core counter through it, pulsing done at completion or err on a
// rejected command. All outputs come straight from registers.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [REP_W-1:0] reps,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             up,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e             state, state_nxt;
  mode_e              mode_r;
  logic [WIDTH-1:0]   lo_r, hi_r;
  logic [REP_W-1:0]   reps_r;
  logic [REP_W-1:0]   pass_cnt, pass_nxt, pass_inc;
  logic               up_nxt, err_nxt, cap;
  logic               ld, en, pass_end;
  logic [WIDTH-1:0]   ld_val;

  assign pass_inc = pass_cnt + 1'b1;

  // Last value of a pass: UP stops at hi, DOWN at lo, PINGPONG on the
  // way back down to lo (or every cycle when the range is a single value)
  always_comb begin
    pass_end = 1'b0;
    case (mode_r)
      MODE_UP:   pass_end = (count == hi_r);
      MODE_DOWN: pass_end = (count == lo_r);
      MODE_PING: pass_end = (lo_r == hi_r) || (!up && count == lo_r);
      default:   pass_end = 1'b0;
    endcase
  end

  // Next-state, datapath control and command validation
  always_comb begin
    state_nxt = state;
    pass_nxt  = pass_cnt;
    up_nxt    = up;
    err_nxt   = 1'b0;
    cap       = 1'b0;
    ld        = 1'b0;
    en        = 1'b0;
    ld_val    = count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (lo > hi || reps == '0 || mode == MODE_RSVD) begin
            err_nxt = 1'b1;
          end else begin
            cap       = 1'b1;
            state_nxt = ST_RUN;
            pass_nxt  = '0;
            ld        = 1'b1;
            ld_val    = (mode == MODE_DOWN) ? hi : lo;
            up_nxt    = (mode != MODE_DOWN);
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!hold) begin
          if (pass_end) begin
            pass_nxt = pass_inc;
            if (pass_inc == reps_r) begin
              state_nxt = ST_DONE;
            end else begin
              ld = 1'b1;
              case (mode_r)
                MODE_UP:   ld_val = lo_r;
                MODE_DOWN: ld_val = hi_r;
                default: begin
                  if (lo_r == hi_r) begin
                    ld_val = lo_r;
                  end else begin
                    ld_val = lo_r + 1'b1;
                    up_nxt = 1'b1;
                  end
                end
              endcase
            end
          end else if (mode_r == MODE_PING && up && count == hi_r) begin
            ld     = 1'b1;
            ld_val = hi_r - 1'b1;
            up_nxt = 1'b0;
          end else begin
            en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, direction, pass counter and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      up       <= 1'b1;
      pass_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      up       <= up_nxt;
      pass_cnt <= pass_nxt;
      busy     <= (state_nxt == ST_RUN);
      done     <= (state_nxt == ST_DONE);
      err      <= err_nxt;
    end
  end

  // Command capture; only meaningful while a sweep is active
  always_ff @(posedge clk) begin
    if (cap) begin
      mode_r <= mode_e'(mode);
      lo_r   <= lo;
      hi_r   <= hi;
      reps_r <= reps;
    end
  end

  updown_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .d    (ld_val),
    .en   (en),
    .up   (up),
    .q    (count)
  );

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with hand-computed expectations.
module tb_counter_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] reps;
  logic       hold;
  logic       abort;
  logic [3:0] count;
  logic       up;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  counter_sweep_ctrl #(.WIDTH(4), .REP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .lo    (lo),
    .hi    (hi),
    .reps  (reps),
    .hold  (hold),
    .abort (abort),
    .count (count),
    .up    (up),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic go(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h,
                    input logic [3:0] r);
    start = 1'b1;
    mode  = m;
    lo    = l;
    hi    = h;
    reps  = r;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int seq_up[8];
    int seq_pp[5];
    int dir_pp[5];
    seq_up = '{2, 3, 4, 5, 2, 3, 4, 5};
    seq_pp = '{1, 2, 3, 2, 1};
    dir_pp = '{1, 1, 1, 0, 0};

    rst = 1'b0; start = 1'b0; mode = 2'b00; lo = 4'd0; hi = 4'd0;
    reps = 4'd0; hold = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_up",    32'(up),    1);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_done",  32'(done),  0);
    chk("rst_err",   32'(err),   0);
    rst = 1'b1;
    tick();

    // reset in the middle of an UP sweep
    go(2'b00, 4'd0, 4'd15, 4'd1);
    tick(); tick(); tick();
    chk("mid_pre_count", 32'(count), 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_busy",  32'(busy),  0);
    tick();
    chk("mid_rst_done",  32'(done),  0);
    rst = 1'b1;
    tick();

    // UP 2..5, two passes
    go(2'b00, 4'd2, 4'd5, 4'd2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("up_count%0d", i), 32'(count), 32'(seq_up[i]));
      chk($sformatf("up_busy%0d", i),  32'(busy),  1);
      chk($sformatf("up_done%0d", i),  32'(done),  0);
      tick();
    end
    chk("up_done_pulse", 32'(done),  1);
    chk("up_done_busy",  32'(busy),  0);
    chk("up_done_count", 32'(count), 5);
    tick();
    chk("up_after_done",  32'(done),  0);
    chk("up_after_count", 32'(count), 5);

    // PINGPONG 1..3, one pass
    go(2'b10, 4'd1, 4'd3, 4'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pp_count%0d", i), 32'(count), 32'(seq_pp[i]));
      chk($sformatf("pp_up%0d", i),    32'(up),    32'(dir_pp[i]));
      chk($sformatf("pp_busy%0d", i),  32'(busy),  1);
      tick();
    end
    chk("pp_done_pulse", 32'(done),  1);
    chk("pp_done_count", 32'(count), 1);
    tick();

    // DOWN with lo==hi==7, three passes
    go(2'b01, 4'd7, 4'd7, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dn_count%0d", i), 32'(count), 7);
      chk($sformatf("dn_up%0d", i),    32'(up),    0);
      chk($sformatf("dn_busy%0d", i),  32'(busy),  1);
      tick();
    end
    chk("dn_done_pulse", 32'(done), 1);
    chk("dn_done_busy",  32'(busy), 0);
    tick();
    chk("dn_idle_done",  32'(done), 0);

    // rejected commands
    go(2'b00, 4'd9, 4'd4, 4'd1);
    chk("rej_lohi_err",   32'(err),   1);
    chk("rej_lohi_busy",  32'(busy),  0);
    chk("rej_lohi_count", 32'(count), 7);
    tick();
    chk("rej_lohi_clear", 32'(err),   0);
    go(2'b00, 4'd1, 4'd2, 4'd0);
    chk("rej_reps_err",   32'(err),   1);
    chk("rej_reps_busy",  32'(busy),  0);
    tick();
    go(2'b11, 4'd1, 4'd2, 4'd1);
    chk("rej_mode_err",   32'(err),   1);
    chk("rej_mode_busy",  32'(busy),  0);
    chk("rej_mode_count", 32'(count), 7);
    tick();
    chk("rej_mode_clear", 32'(err),   0);

    // hold, ignored start, abort in UP 0..15
    go(2'b00, 4'd0, 4'd15, 4'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("hold_pre_count", 32'(count), 6);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold_count%0d", i), 32'(count), 6);
      chk($sformatf("hold_busy%0d", i),  32'(busy),  1);
    end
    hold = 1'b0;
    tick();
    chk("hold_resume", 32'(count), 7);
    go(2'b01, 4'd3, 4'd4, 4'd1);
    chk("ign_start_count", 32'(count), 8);
    chk("ign_start_up",    32'(up),    1);
    chk("ign_start_busy",  32'(busy),  1);
    tick(); tick();
    chk("abort_pre_count", 32'(count), 10);
    abort = 1'b1;
    hold  = 1'b1;
    tick();
    abort = 1'b0;
    hold  = 1'b0;
    chk("abort_busy",  32'(busy),  0);
    chk("abort_done",  32'(done),  0);
    chk("abort_count", 32'(count), 10);
    tick();
    chk("abort_idle_done",  32'(done),  0);
    chk("abort_idle_count", 32'(count), 10);
    chk("abort_idle_err",   32'(err),   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the 4-bit synchronous up/down counter datapath. It accepts a sweep command (range, direction mode, pass count), then steps the counter value, turning direction or reloading at the bounds, and signals completion. It replaces hand-driven `up`/`rst` stimulus with a controlled, repeatable sweep engine, and owns its own counter instance.

## Interface
- `WIDTH`, 4, counter width in bits.
- `REP_W`, 4, width of the pass-count field.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `start`  in  1  command strobe; sampled only in IDLE.
- `mode`  in  2  00 UP, 01 DOWN, 10 PINGPONG, 11 reserved.
- `lo`  in  WIDTH  lower bound, inclusive.
- `hi`  in  WIDTH  upper bound, inclusive.
- `reps`  in  REP_W  number of passes, 1..2^REP_W-1.
- `hold`  in  1  freezes count and FSM while high.
- `abort`  in  1  terminates the sweep, returns to IDLE.
- `count`  out  WIDTH  current counter value.
- `up`  out  1  current step direction, 1 = increment.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the final value of a completed sweep.
- `err`  out  1  one-cycle pulse on a rejected command.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 captures `mode`, `lo`, `hi`, `reps`.
  - Rejected if `lo`>`hi`, `reps`=0, or `mode`=11: state stays IDLE, `err` pulses next cycle, `count` unchanged.
  - Otherwise go to RUN. On the same edge `count` loads `lo` (UP, PINGPONG) or `hi` (DOWN). `up` is set to 1 for UP/PINGPONG, 0 for DOWN.
- RUN: each edge with `hold`=0 advances one step.
  - UP: a pass ends at `hi`; the next pass reloads `lo` directly (`hi`→`lo` in one edge).
  - DOWN: mirror of UP; a pass ends at `lo`, then reloads `hi`.
  - PINGPONG: at `hi`, `up`←0 and `count` steps to `hi`-1. A pass ends on return to `lo`; the next pass steps `lo`+1 with `up`←1.
  - `lo`==`hi`: each pass is one cycle at that value, in all modes.
  - Internal pass counter increments at each pass end. On the final pass end, the next edge enters DONE and `count` holds.
- DONE: lasts one cycle. `done`=1, `busy`=0, then IDLE.
- `hold`=1 in RUN: `count`, `up`, the pass counter and the state all hold.
- `abort`=1 in RUN or DONE: IDLE on the next edge, `count` holds, no `done`/`err` pulse.
  - `abort` has priority over `hold` and over pass end.
- `start` outside IDLE is ignored (not queued).
- Arithmetic is modulo 2^WIDTH, but the bounds guarantee no wrap.
- `count` holds its last value in IDLE.

## Timing
- Reset values: `count`=0, `up`=1, `busy`=0, `done`=0, `err`=0, state IDLE, pass counter 0. Reset applies immediately at the `rst` fall, including mid-sweep.
- All outputs are registered; no combinational input-to-output path.
- `busy` rises on the edge that samples a valid `start`, and falls on the edge entering DONE.
- Sweep latency without hold: UP/DOWN take `reps`×(`hi`-`lo`+1) busy cycles. PINGPONG takes 1+`reps`×2×(`hi`-`lo`) busy cycles, with `lo`==`hi` taking `reps` cycles. `done` follows one cycle after the last busy cycle.
- A new `start` is accepted in the cycle `done`=1? No: only once back in IDLE, i.e. the cycle after `done`.

## Structure
- Package `counter_pkg` holds:
  - the `mode` encodings (MODE_UP, MODE_DOWN, MODE_PING, MODE_RSVD);
  - the FSM state enum;
  - the default `WIDTH`/`REP_W` constants.
- Sub-module `updown_core`: WIDTH-bit register with `load`, `d`, `en`, `up` and `q`, async active-low reset. It is the datapath; the FSM and pass counter live in the top.

## Test plan
- Reset mid-sweep: assert `rst`=0 at step 3 of a UP sweep → `count`=0, `busy`=0 immediately; no `done`.
- UP, `lo`=2, `hi`=5, `reps`=2 → `count` 2,3,4,5,2,3,4,5; 8 busy cycles; `done` one cycle later; `count` holds 5.
- PINGPONG, `lo`=1, `hi`=3, `reps`=1 → `count` 1,2,3,2,1; `up` falls at 3; `done` after the final 1.
- DOWN, `lo`=`hi`=7, `reps`=3 → `count`=7 for 3 busy cycles, then `done`.
- Rejects: `lo`=9, `hi`=4; then `reps`=0; then `mode`=11 → each gives an `err` pulse; `busy` stays 0; `count` unchanged.
- Hold and abort in UP 0..15:
  - `hold` for 4 cycles at `count`=6 → `count` frozen at 6, then resumes at 7.
  - `abort` at 10 → IDLE, `count`=10, no `done`.
  - `start` during busy → ignored.
